// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//    Shares the register file's single write port between two producers
//    (requester 0 = ALU result, requester 1 = load/secondary unit). Each
//    requester pushes (rd, data) pairs through a valid/ready handshake into its
//    own 2-entry FIFO. A round-robin arbiter pops at most one head entry per
//    cycle and issues a registered write command. Writes to x0 are consumed
//    (popped, grant_vld high) but rf_reg_write is held low.
//
// Ports:
//    clk            rising-edge clock
//    reset          asynchronous, active-low reset
//    req0_valid/rd/data, req0_ready   requester 0 handshake
//    req1_valid/rd/data, req1_ready   requester 1 handshake
//    rf_reg_write   register file write enable (registered)
//    rf_rd          register file destination index (registered)
//    rf_write_data  register file write data (registered)
//    grant_id       requester driving rf_* this cycle (registered)
//    grant_vld      an entry was popped on the previous edge (registered)
//    idle           both queues empty and no grant in flight
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_rd,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_rd,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              grant_id,
   output logic              grant_vld,
   output logic              idle
);

   // Requester-indexed views of the two input ports
   logic [1:0]             req_valid;
   logic [1:0][ADDR_W-1:0] req_rd;
   logic [1:0][DATA_W-1:0] req_data;

   assign req_valid = {req1_valid, req0_valid};
   assign req_rd    = {req1_rd, req0_rd};
   assign req_data  = {req1_data, req0_data};

   // Per-queue status and head entries
   logic [1:0]             q_ready;
   logic [1:0]             q_nonempty;
   logic [1:0]             q_push;
   logic [1:0]             q_pop;
   logic [1:0][ADDR_W-1:0] head_rd;
   logic [1:0][DATA_W-1:0] head_data;

   // Arbitration results
   logic grant_any;
   logic grant_sel;
   logic rr_ptr_reg;
   logic rr_next;

   // Registered outputs
   logic              rf_reg_write_reg;
   logic [ADDR_W-1:0] rf_rd_reg;
   logic [DATA_W-1:0] rf_write_data_reg;
   logic              grant_id_reg;
   logic              grant_vld_reg;

   // --------------------------------------------------------------------------
   // Two-entry circular FIFO per requester
   // --------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_queue
         logic [1:0]        count_reg;
         logic [1:0]        count_next;
         logic              rd_ptr_reg;
         logic              wr_ptr_reg;
         logic [ADDR_W-1:0] q_rd_mem   [2];
         logic [DATA_W-1:0] q_data_mem [2];

         // Ready depends only on the registered count: a full queue refuses
         // a push even in a cycle where it is also being popped.
         assign q_ready[gi]    = (count_reg != 2'd2);
         assign q_nonempty[gi] = (count_reg != 2'd0);
         assign q_push[gi]     = req_valid[gi] && q_ready[gi];
         assign q_pop[gi]      = grant_any && (grant_sel == 1'(gi));
         assign head_rd[gi]    = q_rd_mem[rd_ptr_reg];
         assign head_data[gi]  = q_data_mem[rd_ptr_reg];

         always_comb begin
            count_next = count_reg;
            case ({q_push[gi], q_pop[gi]})
               2'b10:   count_next = count_reg + 2'd1;
               2'b01:   count_next = count_reg - 2'd1;
               default: count_next = count_reg;
            endcase
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               count_reg  <= 2'd0;
               rd_ptr_reg <= 1'b0;
               wr_ptr_reg <= 1'b0;
            end else begin
               count_reg <= count_next;
               if (q_push[gi]) wr_ptr_reg <= ~wr_ptr_reg;
               if (q_pop[gi])  rd_ptr_reg <= ~rd_ptr_reg;
            end
         end

         // Entry storage needs no reset; validity is tracked by count_reg.
         always_ff @(posedge clk) begin
            if (q_push[gi]) begin
               q_rd_mem[wr_ptr_reg]   <= req_rd[gi];
               q_data_mem[wr_ptr_reg] <= req_data[gi];
            end
         end
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Round-robin arbitration on queue heads. The pointer only moves when both
   // queues contend, so a lone requester never steals priority.
   // --------------------------------------------------------------------------
   always_comb begin
      grant_any = 1'b0;
      grant_sel = 1'b0;
      rr_next   = rr_ptr_reg;
      if (q_nonempty[0] && q_nonempty[1]) begin
         grant_any = 1'b1;
         grant_sel = rr_ptr_reg;
         rr_next   = ~rr_ptr_reg;
      end else if (q_nonempty[0]) begin
         grant_any = 1'b1;
         grant_sel = 1'b0;
      end else if (q_nonempty[1]) begin
         grant_any = 1'b1;
         grant_sel = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Registered write command. rf_rd / rf_write_data / grant_id hold their
   // last values when nothing is granted.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_reg        <= 1'b0;
         rf_reg_write_reg  <= 1'b0;
         rf_rd_reg         <= '0;
         rf_write_data_reg <= '0;
         grant_id_reg      <= 1'b0;
         grant_vld_reg     <= 1'b0;
      end else begin
         rr_ptr_reg       <= rr_next;
         grant_vld_reg    <= grant_any;
         // x0 writes are popped and reported but never enabled
         rf_reg_write_reg <= grant_any && (head_rd[grant_sel] != '0);
         if (grant_any) begin
            grant_id_reg      <= grant_sel;
            rf_rd_reg         <= head_rd[grant_sel];
            rf_write_data_reg <= head_data[grant_sel];
         end
      end
   end

   assign rf_reg_write  = rf_reg_write_reg;
   assign rf_rd         = rf_rd_reg;
   assign rf_write_data = rf_write_data_reg;
   assign grant_id      = grant_id_reg;
   assign grant_vld     = grant_vld_reg;
   assign req0_ready    = q_ready[0];
   assign req1_ready    = q_ready[1];
   assign idle          = !q_nonempty[0] && !q_nonempty[1] && !grant_vld_reg;

endmodule
